// File: rtl/aurora_link_pkg.sv
// Shared definitions for the Aurora lane arbiter.
//   link_state_e : link-state encodings (DOWN/SYNC/RUN) as driven on link_state.
//   WordCredit/WordFlit : values of the type bit (MSB) of a lane word.
//   word_width() : lane word width = flit + port id + type bit.
package aurora_link_pkg;

  typedef enum logic [1:0] {
    LinkDown = 2'd0,
    LinkSync = 2'd1,
    LinkRun  = 2'd2
  } link_state_e;

  localparam logic WordCredit = 1'b1;
  localparam logic WordFlit   = 1'b0;

  function automatic int unsigned word_width(input int unsigned flit_w, input int unsigned pid_w);
    return flit_w + pid_w + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector, one bit per requester.
//   ptr   : highest-priority index this cycle (search starts here and wraps).
//   grant : one-hot grant, zero when no request is set.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aurora_link_arbiter.sv
// Shares one Aurora lane between NUM_PORTS router links.
// TX: after link-up, advertises every port's local nonFullVCs (SYNC), then in RUN
// sends changed credit words first and otherwise round-robins flits whose target
// VC is known non-full on the far side. RX: demuxes flit words to out_flit/
// out_flit_valid and credit words into remote_nonfull.
// Ports:
//   CLK, RST_N            : user clock, synchronous active-low reset
//   channel_up            : Aurora CHANNEL_UP; low forces DOWN immediately
//   in_flit_valid/in_flit : per-port flit requests; in_flit_accept one-hot consume
//   local_nonfull         : local nonFullVCs to advertise
//   tx_data/tx_valid/tx_ready : lane TX word handshake
//   rx_data/rx_valid      : lane RX word (no backpressure)
//   out_flit/out_flit_valid : received flit, one-hot destination pulse
//   remote_nonfull        : far-side nonFullVCs minus flits in flight
//   link_state            : 0 DOWN, 1 SYNC, 2 RUN
// Optional: define AURORA_LINK_STATS_EN to add tx_flit_cnt, rx_flit_cnt and
// rx_drop_cnt saturating counters.
module aurora_link_arbiter
  import aurora_link_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned FLIT_W    = 21,
  parameter int unsigned NUM_VCS   = 2,
  parameter int unsigned VC_LSB    = 17,
  parameter int unsigned PID_W     = 1,
  localparam int unsigned WORD_W   = word_width(FLIT_W, PID_W)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         channel_up,
  input  logic [NUM_PORTS-1:0]         in_flit_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0]  in_flit,
  output logic [NUM_PORTS-1:0]         in_flit_accept,
  input  logic [NUM_PORTS*NUM_VCS-1:0] local_nonfull,
  output logic [WORD_W-1:0]            tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic [WORD_W-1:0]            rx_data,
  input  logic                         rx_valid,
  output logic [FLIT_W-1:0]            out_flit,
  output logic [NUM_PORTS-1:0]         out_flit_valid,
  output logic [NUM_PORTS*NUM_VCS-1:0] remote_nonfull,
  output logic [1:0]                   link_state
`ifdef AURORA_LINK_STATS_EN
  ,
  output logic [31:0]                  tx_flit_cnt,
  output logic [31:0]                  rx_flit_cnt,
  output logic [31:0]                  rx_drop_cnt
`endif
);

  localparam int unsigned VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned SIDX_W = $clog2(NUM_PORTS + 1);

  link_state_e                  state_q;
  logic [WORD_W-1:0]            tx_data_q;
  logic                         tx_valid_q;
  logic [PTR_W-1:0]             rr_ptr_q;
  logic [SIDX_W-1:0]            sync_idx_q;
  logic [NUM_PORTS*NUM_VCS-1:0] last_sent_q;
  logic [NUM_PORTS*NUM_VCS-1:0] rnf_q;
  logic [FLIT_W-1:0]            out_flit_q;
  logic [NUM_PORTS-1:0]         out_flit_valid_q;

  logic [VC_W-1:0]      vc_of [NUM_PORTS];
  logic [NUM_PORTS-1:0] flit_req;
  logic [NUM_PORTS-1:0] grant;
  logic                 credit_pending;
  int unsigned          credit_sel;
  int unsigned          grant_sel;
  int unsigned          cred_port;
  logic                 load_en, running, syncing;
  logic                 do_sync, do_credit, do_flit, do_load;
  logic [WORD_W-1:0]    load_word;

  logic                 rx_is_credit;
  logic [PID_W-1:0]     rx_pid;
  logic                 rx_pid_ok;

  // A flit may only go if its target VC is currently known non-full remotely.
  always_comb begin
    flit_req = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      vc_of[p]    = in_flit[p*FLIT_W + VC_LSB +: VC_W];
      flit_req[p] = in_flit_valid[p] && (32'(vc_of[p]) < NUM_VCS) &&
                    rnf_q[p*NUM_VCS + 32'(vc_of[p])];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_PORTS)
  ) u_rr_arbiter (
    .req   (flit_req),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Lowest port whose advertised credit is stale, and index of the granted port.
  always_comb begin
    credit_pending = 1'b0;
    credit_sel     = 0;
    grant_sel      = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!credit_pending &&
          (local_nonfull[p*NUM_VCS +: NUM_VCS] != last_sent_q[p*NUM_VCS +: NUM_VCS])) begin
        credit_pending = 1'b1;
        credit_sel     = p;
      end
      if (grant[p]) grant_sel = p;
    end
  end

  assign load_en   = !tx_valid_q || tx_ready;
  assign running   = channel_up && (state_q == LinkRun);
  assign syncing   = channel_up && (state_q == LinkSync);
  assign do_sync   = syncing && load_en && (sync_idx_q < SIDX_W'(NUM_PORTS));
  assign do_credit = running && load_en && credit_pending;
  assign do_flit   = running && load_en && !credit_pending && (|grant);
  assign do_load   = do_sync || do_credit || do_flit;

  always_comb begin
    cred_port = do_sync ? 32'(sync_idx_q) : credit_sel;
    load_word = '0;
    if (do_flit) begin
      load_word[WORD_W-1]         = WordFlit;
      load_word[FLIT_W +: PID_W]  = PID_W'(grant_sel);
      load_word[FLIT_W-1:0]       = in_flit[grant_sel*FLIT_W +: FLIT_W];
    end else begin
      load_word[WORD_W-1]         = WordCredit;
      load_word[FLIT_W +: PID_W]  = PID_W'(cred_port);
      load_word[NUM_VCS-1:0]      = local_nonfull[cred_port*NUM_VCS +: NUM_VCS];
    end
  end

  assign rx_is_credit = (rx_data[WORD_W-1] == WordCredit);
  assign rx_pid       = rx_data[FLIT_W +: PID_W];
  assign rx_pid_ok    = (32'(rx_pid) < NUM_PORTS);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q          <= LinkDown;
      tx_data_q        <= '0;
      tx_valid_q       <= 1'b0;
      rr_ptr_q         <= '0;
      sync_idx_q       <= '0;
      last_sent_q      <= '0;
      rnf_q            <= '0;
      out_flit_q       <= '0;
      out_flit_valid_q <= '0;
    end else if (!channel_up) begin
      // Lane lost: drop the held word and forget far-side credit.
      state_q          <= LinkDown;
      tx_data_q        <= '0;
      tx_valid_q       <= 1'b0;
      sync_idx_q       <= '0;
      rnf_q            <= '0;
      out_flit_valid_q <= '0;
    end else begin
      out_flit_valid_q <= '0;

      if (tx_valid_q && tx_ready) tx_valid_q <= 1'b0;
      if (do_load) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= load_word;
      end
      if (do_sync || do_credit) begin
        last_sent_q[cred_port*NUM_VCS +: NUM_VCS] <= local_nonfull[cred_port*NUM_VCS +: NUM_VCS];
      end
      if (do_flit) begin
        rr_ptr_q <= (grant_sel == NUM_PORTS - 1) ? '0 : PTR_W'(grant_sel + 1);
        rnf_q[grant_sel*NUM_VCS + 32'(vc_of[grant_sel])] <= 1'b0;
      end

      unique case (state_q)
        LinkDown: begin
          state_q    <= LinkSync;
          sync_idx_q <= '0;
        end
        LinkSync: begin
          if (do_sync) begin
            sync_idx_q <= sync_idx_q + SIDX_W'(1);
          end else if ((sync_idx_q == SIDX_W'(NUM_PORTS)) && tx_valid_q && tx_ready) begin
            state_q <= LinkRun;
          end
        end
        LinkRun: ;
        default: state_q <= LinkDown;
      endcase

      // Placed after the flit-load clear so a same-cycle received credit wins.
      if (rx_valid && rx_pid_ok && (state_q != LinkDown)) begin
        if (rx_is_credit) begin
          rnf_q[32'(rx_pid)*NUM_VCS +: NUM_VCS] <= rx_data[NUM_VCS-1:0];
        end else if (state_q == LinkRun) begin
          out_flit_q               <= rx_data[FLIT_W-1:0];
          out_flit_valid_q[rx_pid] <= 1'b1;
        end
      end
    end
  end

  // Link loss is visible in the same cycle channel_up falls.
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q && channel_up;
  assign in_flit_accept = do_flit ? grant : '0;
  assign out_flit       = out_flit_q;
  assign out_flit_valid = out_flit_valid_q;
  assign remote_nonfull = channel_up ? rnf_q : '0;
  assign link_state     = channel_up ? state_q : LinkDown;

`ifdef AURORA_LINK_STATS_EN
  logic [31:0] tx_flit_cnt_q, rx_flit_cnt_q, rx_drop_cnt_q;
  logic        tx_flit_hs, rx_flit_dlv, rx_drop;

  assign tx_flit_hs  = channel_up && tx_valid_q && tx_ready && (tx_data_q[WORD_W-1] == WordFlit);
  assign rx_flit_dlv = channel_up && (state_q == LinkRun) && rx_valid && !rx_is_credit &&
                       rx_pid_ok;
  assign rx_drop     = channel_up && (state_q != LinkDown) && rx_valid && !rx_pid_ok;

  always_ff @(posedge CLK) begin
    if (!RST_N || !channel_up) begin
      tx_flit_cnt_q <= '0;
      rx_flit_cnt_q <= '0;
      rx_drop_cnt_q <= '0;
    end else begin
      if (tx_flit_hs && (tx_flit_cnt_q != '1)) tx_flit_cnt_q <= tx_flit_cnt_q + 32'd1;
      if (rx_flit_dlv && (rx_flit_cnt_q != '1)) rx_flit_cnt_q <= rx_flit_cnt_q + 32'd1;
      if (rx_drop && (rx_drop_cnt_q != '1)) rx_drop_cnt_q <= rx_drop_cnt_q + 32'd1;
    end
  end

  assign tx_flit_cnt = tx_flit_cnt_q;
  assign rx_flit_cnt = rx_flit_cnt_q;
  assign rx_drop_cnt = rx_drop_cnt_q;
`endif

endmodule
